// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier with start/busy/done handshake.
// Processes D bits of b per clock, most significant digit first (Horner order).
module gf2m_digit_mult #(
  parameter int            M    = 163,
  parameter logic [M-1:0]  POLY = 163'hC9,
  parameter int            D    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] result
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (D < 1 || D > M) begin : g_bad_digit
      $error("gf2m_digit_mult: digit size D must lie in 1..M");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [M-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [M-1:0]    c;
  logic [M-1:0]    c_next;
  logic [CW-1:0]   cnt;

  // Multiply by x and fold the overflow bit back in through f(x).
  function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  function automatic logic [M-1:0] digit_step(input logic [M-1:0] acc,
                                              input logic [M-1:0] op,
                                              input logic [D-1:0] dig);
    logic [M-1:0] shifted;
    logic [M-1:0] pp;
    logic [M-1:0] ak;
    shifted = acc;
    for (int i = 0; i < D; i++) shifted = mulx(shifted);
    pp = '0;
    ak = op;
    for (int k = 0; k < D; k++) begin
      if (dig[k]) pp = pp ^ ak;
      ak = mulx(ak);
    end
    return shifted ^ pp;
  endfunction

  // b_reg shifts left each step so the current digit always sits at the top.
  assign c_next = digit_step(c, a_reg, b_reg[W-1 -: D]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      c      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= W'(b);
            c     <= '0;
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          c     <= c_next;
          b_reg <= b_reg << D;
          if (cnt == '0) begin
            result <= c_next;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Self-checking bench: four multiplier instances (GF(2^8) and B-163 with D=1/4/8)
// compared against a product-then-reduce polynomial reference model.
module tb_gf2m_digit_mult;

  logic clk = 1'b0;
  logic rst_n;

  logic         start8, busy8, done8;
  logic [7:0]   a8, b8, res8;
  logic         start1, busy1, done1;
  logic [162:0] a1, b1, res1;
  logic         start4, busy4, done4;
  logic [162:0] a4, b4, res4;
  logic         startx, busyx, donex;
  logic [162:0] ax, bx, resx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf2m_digit_mult #(.M(8), .POLY(8'h1B), .D(1)) u_m8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8));
  gf2m_digit_mult #(.M(163), .D(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1));
  gf2m_digit_mult #(.M(163), .D(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4));
  gf2m_digit_mult #(.M(163), .D(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(startx), .a(ax), .b(bx),
    .busy(busyx), .done(donex), .result(resx));

  // Full carry-less product first, then long division by f(x).
  function automatic logic [162:0] refMul(input logic [162:0] x, input logic [162:0] y,
                                          input int m, input logic [162:0] poly);
    logic [325:0] prod;
    logic [325:0] f;
    prod = '0;
    f = {163'b0, poly};
    f[m] = 1'b1;
    for (int i = 0; i < m; i++)
      if (y[i]) prod = prod ^ ({163'b0, x} << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (prod[i]) prod = prod ^ (f << (i - m));
    return prod[162:0];
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[162:0];
  endfunction

  function automatic logic getBusy(input int sel);
    case (sel)
      0: return busy8;
      1: return busy1;
      2: return busy4;
      default: return busyx;
    endcase
  endfunction

  function automatic logic getDone(input int sel);
    case (sel)
      0: return done8;
      1: return done1;
      2: return done4;
      default: return donex;
    endcase
  endfunction

  function automatic logic [162:0] getResult(input int sel);
    case (sel)
      0: return {155'b0, res8};
      1: return res1;
      2: return res4;
      default: return resx;
    endcase
  endfunction

  task automatic applyStimulus(input int sel, input logic s,
                               input logic [162:0] x, input logic [162:0] y);
    case (sel)
      0: begin start8 = s; a8 = x[7:0]; b8 = y[7:0]; end
      1: begin start1 = s; a1 = x; b1 = y; end
      2: begin start4 = s; a4 = x; b4 = y; end
      default: begin startx = s; ax = x; bx = y; end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [162:0] obs,
                             input logic [162:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated multiply; operands are scrambled right after acceptance.
  task automatic runOp(input int sel, input logic [162:0] x, input logic [162:0] y,
                       output logic [162:0] res, output int lat,
                       output int busy_cycles, output int done_after);
    bit seen;
    applyStimulus(sel, 1'b1, x, y);
    @(posedge clk); #1;
    applyStimulus(sel, 1'b0, rand163(), rand163());
    lat = -1;
    res = '0;
    seen = 1'b0;
    busy_cycles = getBusy(sel) ? 1 : 0;
    done_after = 0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(posedge clk); #1;
      if (getBusy(sel)) busy_cycles++;
      if (getDone(sel)) begin
        lat = k;
        res = getResult(sel);
        seen = 1'b1;
      end
    end
    @(posedge clk); #1;
    done_after = getDone(sel) ? 1 : 0;
  endtask

  initial begin
    logic [162:0] x, y, y2, r, r2, ones;
    int lat, bc, extra, dcount, t1, t2;
    int nsel [2];
    int nval [2];

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) applyStimulus(s, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      checkOutput("reset_busy", 163'(getBusy(s)), '0);
      checkOutput("reset_done", 163'(getDone(s)), '0);
      checkOutput("reset_result", getResult(s), '0);
    end

    $display("[TB] GF(2^8) known products");
    runOp(0, 163'h57, 163'h83, r, lat, bc, extra);
    checkOutput("m8_57x83", r, 163'hC1);
    checkOutput("m8_lat", 163'(lat), 163'd8);
    checkOutput("m8_busy", 163'(bc), 163'd8);
    checkOutput("m8_single_done", 163'(extra), '0);
    runOp(0, 163'h57, 163'h13, r, lat, bc, extra);
    checkOutput("m8_57x13", r, 163'hFE);
    for (int i = 0; i < 4; i++) begin
      x = 163'($urandom_range(255));
      y = 163'($urandom_range(255));
      runOp(0, x, y, r, lat, bc, extra);
      checkOutput("m8_rand", r, refMul(x, y, 8, 163'h1B));
    end

    $display("[TB] B-163 D=1 reduction cases");
    y = '0; y[162] = 1'b1;
    runOp(1, 163'd1, y, r, lat, bc, extra);
    checkOutput("d1_one_x_top", r, y);
    checkOutput("d1_lat", 163'(lat), 163'd163);
    checkOutput("d1_busy", 163'(bc), 163'd163);
    runOp(1, 163'd2, y, r, lat, bc, extra);
    checkOutput("d1_reduce", r, 163'hC9);

    $display("[TB] B-163 random operands, D=4 and D=8");
    nsel[0] = 2; nval[0] = 41;
    nsel[1] = 3; nval[1] = 21;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 20; i++) begin
        x = rand163();
        y = rand163();
        runOp(nsel[d], x, y, r, lat, bc, extra);
        checkOutput("rand_result", r, refMul(x, y, 163, 163'hC9));
        checkOutput("rand_lat", 163'(lat), 163'(nval[d]));
        checkOutput("rand_busy", 163'(bc), 163'(nval[d]));
        checkOutput("rand_single_done", 163'(extra), '0);
      end
    end

    $display("[TB] start during a run is ignored");
    x = rand163(); y = rand163();
    applyStimulus(2, 1'b1, x, y);
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, x, y);
    repeat (4) begin @(posedge clk); #1; end
    applyStimulus(2, 1'b1, rand163(), rand163());
    @(posedge clk); #1;
    applyStimulus(2, 1'b0, rand163(), rand163());
    dcount = 0; lat = -1; r = '0;
    for (int k = 6; k <= 120; k++) begin
      @(posedge clk); #1;
      if (done4) begin
        dcount++;
        if (dcount == 1) begin lat = k; r = res4; end
      end
    end
    checkOutput("ignore_done_count", 163'(dcount), 163'd1);
    checkOutput("ignore_lat", 163'(lat), 163'd41);
    checkOutput("ignore_result", r, refMul(x, y, 163, 163'hC9));

    $display("[TB] start held high through done");
    x = rand163(); y = rand163(); y2 = rand163();
    applyStimulus(3, 1'b1, x, y);
    @(posedge clk); #1;
    dcount = 0; t1 = -1; t2 = -1; r = '0; r2 = '0;
    for (int k = 1; k <= 100 && dcount < 2; k++) begin
      @(posedge clk); #1;
      if (t1 > 0 && k == t1 + 1) applyStimulus(3, 1'b0, rand163(), rand163());
      if (donex) begin
        dcount++;
        if (dcount == 1) begin
          t1 = k; r = resx;
          applyStimulus(3, 1'b1, y2, x);
        end else begin
          t2 = k; r2 = resx;
        end
      end
    end
    applyStimulus(3, 1'b0, '0, '0);
    checkOutput("b2b_done_count", 163'(dcount), 163'd2);
    checkOutput("b2b_first_lat", 163'(t1), 163'd21);
    checkOutput("b2b_spacing", 163'(t2 - t1), 163'd22);
    checkOutput("b2b_first_result", r, refMul(x, y, 163, 163'hC9));
    checkOutput("b2b_second_result", r2, refMul(y2, x, 163, 163'hC9));

    $display("[TB] reset mid-run");
    x = rand163(); y = rand163();
    applyStimulus(1, 1'b1, x, y);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, x, y);
    repeat (49) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midrst_busy", 163'(busy1), '0);
    checkOutput("midrst_done", 163'(done1), '0);
    checkOutput("midrst_result", res1, '0);
    dcount = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done1) dcount++;
    end
    checkOutput("midrst_no_done", 163'(dcount), '0);
    runOp(1, x, y, r, lat, bc, extra);
    checkOutput("midrst_fresh", r, refMul(x, y, 163, 163'hC9));

    $display("[TB] edge operands and result hold");
    runOp(2, '0, rand163(), r, lat, bc, extra);
    checkOutput("edge_zero", r, '0);
    ones = '1;
    runOp(2, ones, 163'd1, r, lat, bc, extra);
    checkOutput("edge_ones", r, ones);
    dcount = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (res4 !== r || done4) dcount++;
    end
    checkOutput("edge_hold", 163'(dcount), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
